core_mem_responder: RTL and testbench

- Memory-side responder for the per-thread data channels that a compute core exposes: N consumer read channels and N consumer write channels.
- Arbitrates consumers round-robin onto one external memory port (read + write) and relays the response back to the requesting consumer.
- Sits between a core's data_mem channels and the shared data memory; one instance per core.

---
 rtl/core_mem_responder.sv | 127 ++++++++++++
 tb/tb_core_mem_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_responder.sv
// core_mem_responder: round-robin arbiter relaying N consumer read/write channels onto one memory port
// Ports:
//   clk, reset                         clock, synchronous active-low reset
//   consumer_read_valid/address        per-consumer read requests (flattened addresses)
//   consumer_read_ready/data           per-consumer read response, data held until overwritten
//   consumer_write_valid/address/data  per-consumer write requests (flattened)
//   consumer_write_ready               per-consumer write acknowledge
//   mem_read_valid/address             memory read request, held until mem_read_ready
//   mem_read_ready/data                memory read completion and data
//   mem_write_valid/address/data       memory write request, held until mem_write_ready
//   mem_write_ready                    memory write completion
module core_mem_responder #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,
    output logic                               mem_write_valid,
    output logic [ADDR_BITS-1:0]               mem_write_address,
    output logic [DATA_BITS-1:0]               mem_write_data,
    input  logic                               mem_write_ready
);
    localparam int IW = NUM_CONSUMERS > 1 ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY} state_t;

    state_t                           state_q;
    logic [IW-1:0]                    idx_q, rr_q, idx_d, rr_d;
    logic                             found_d;
    logic [NUM_CONSUMERS-1:0]         cand;
    logic [NUM_CONSUMERS-1:0]         rd_ready_q, wr_ready_q;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] rd_data_q;
    logic                             mrv_q, mwv_q;
    logic [ADDR_BITS-1:0]             mra_q, mwa_q;
    logic [DATA_BITS-1:0]             mwd_q;

    assign cand = consumer_read_valid | consumer_write_valid;

    // Scan from the highest offset down so the candidate closest above rr_q wins.
    always_comb begin
        idx_d   = '0;
        found_d = 1'b0;
        for (int j = NUM_CONSUMERS - 1; j >= 0; j--) begin
            if (cand[(int'(rr_q) + j) % NUM_CONSUMERS]) begin
                idx_d   = IW'((int'(rr_q) + j) % NUM_CONSUMERS);
                found_d = 1'b1;
            end
        end
        rr_d = (idx_d == IW'(NUM_CONSUMERS - 1)) ? '0 : idx_d + IW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            rr_q       <= '0;
            rd_ready_q <= '0;
            wr_ready_q <= '0;
            rd_data_q  <= '0;
            mrv_q      <= 1'b0;
            mwv_q      <= 1'b0;
            mra_q      <= '0;
            mwa_q      <= '0;
            mwd_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (found_d) begin
                    idx_q <= idx_d;
                    rr_q  <= rr_d;
                    // A consumer with both requests pending gets its read first.
                    if (consumer_read_valid[idx_d]) begin
                        mrv_q   <= 1'b1;
                        mra_q   <= consumer_read_address[idx_d*ADDR_BITS +: ADDR_BITS];
                        state_q <= READ_WAIT;
                    end else begin
                        mwv_q   <= 1'b1;
                        mwa_q   <= consumer_write_address[idx_d*ADDR_BITS +: ADDR_BITS];
                        mwd_q   <= consumer_write_data[idx_d*DATA_BITS +: DATA_BITS];
                        state_q <= WRITE_WAIT;
                    end
                end
                READ_WAIT: if (mem_read_ready) begin
                    rd_data_q[idx_q*DATA_BITS +: DATA_BITS] <= mem_read_data;
                    rd_ready_q[idx_q] <= 1'b1;
                    mrv_q             <= 1'b0;
                    state_q           <= READ_RELAY;
                end
                WRITE_WAIT: if (mem_write_ready) begin
                    wr_ready_q[idx_q] <= 1'b1;
                    mwv_q             <= 1'b0;
                    state_q           <= WRITE_RELAY;
                end
                READ_RELAY: if (!consumer_read_valid[idx_q]) begin
                    rd_ready_q <= '0;
                    state_q    <= IDLE;
                end
                WRITE_RELAY: if (!consumer_write_valid[idx_q]) begin
                    wr_ready_q <= '0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign consumer_read_ready  = rd_ready_q;
    assign consumer_read_data   = rd_data_q;
    assign consumer_write_ready = wr_ready_q;
    assign mem_read_valid       = mrv_q;
    assign mem_read_address     = mra_q;
    assign mem_write_valid      = mwv_q;
    assign mem_write_address    = mwa_q;
    assign mem_write_data       = mwd_q;
endmodule

// File: tb/tb_core_mem_responder.sv
// tb_core_mem_responder: directed scoreboard bench for core_mem_responder with a latency-configurable memory model
module tb_core_mem_responder;
    localparam int N  = 4;
    localparam int AB = 8;
    localparam int DB = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    rv = '0, wv = '0;
    logic [N*AB-1:0] rva = '0, wva = '0;
    logic [N*DB-1:0] wvd = '0;
    logic [N-1:0]    consumer_read_ready, consumer_write_ready;
    logic [N*DB-1:0] consumer_read_data;
    logic            mem_read_valid, mem_write_valid;
    logic [AB-1:0]   mem_read_address, mem_write_address;
    logic [DB-1:0]   mem_write_data;
    logic            mem_read_ready = 1'b0, mem_write_ready = 1'b0;
    logic [DB-1:0]   mem_read_data = '0;

    core_mem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N)) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv), .consumer_read_address(rva),
        .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
        .consumer_write_valid(wv), .consumer_write_address(wva), .consumer_write_data(wvd),
        .consumer_write_ready(consumer_write_ready),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
    );

    always #5 clk = ~clk;

    typedef struct {bit wr; int idx; logic [7:0] data;} resp_t;
    typedef struct {bit wr; logic [7:0] addr; logic [7:0] data;} mreq_t;

    resp_t        rq[$];
    mreq_t        mq[$];
    logic [7:0]   mem_arr [256];
    int           total = 0, bad = 0, lat = 0, rcnt = 0, wcnt = 0;
    bit           inj_r = 1'b0;
    logic [N-1:0] p_rr = '0, p_wr = '0, p_rv = '0, p_wv = '0;
    logic         p_mrv = 1'b0, p_mwv = 1'b0;
    logic [7:0]   p_mra = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, then act as consumers and memory just after the rising edge.
    task automatic tick();
        resp_t r;
        mreq_t m;
        @(negedge clk);
        chk("ready_onehot", 32'($onehot0({consumer_read_ready, consumer_write_ready})), 1);
        chk("mem_exclusive", 32'(mem_read_valid & mem_write_valid), 0);
        for (int i = 0; i < N; i++) begin
            if (consumer_read_ready[i] && !p_rr[i]) begin
                chk("rd_expected", 32'(rq.size() > 0), 1);
                if (rq.size() > 0) begin
                    r = rq.pop_front();
                    chk("rd_kind", 32'(r.wr), 0);
                    chk("rd_idx", i, r.idx);
                    chk("rd_data", 32'(consumer_read_data[i*DB +: DB]), 32'(r.data));
                end
            end
            if (consumer_write_ready[i] && !p_wr[i]) begin
                chk("wr_expected", 32'(rq.size() > 0), 1);
                if (rq.size() > 0) begin
                    r = rq.pop_front();
                    chk("wr_kind", 32'(r.wr), 1);
                    chk("wr_idx", i, r.idx);
                end
            end
            if (p_rr[i] && !p_rv[i]) chk("rd_ready_drop", 32'(consumer_read_ready[i]), 0);
            if (p_wr[i] && !p_wv[i]) chk("wr_ready_drop", 32'(consumer_write_ready[i]), 0);
        end
        if (mem_read_valid && !p_mrv) begin
            chk("mreq_rd_expected", 32'(mq.size() > 0), 1);
            if (mq.size() > 0) begin
                m = mq.pop_front();
                chk("mreq_rd_kind", 32'(m.wr), 0);
                chk("mreq_rd_addr", 32'(mem_read_address), 32'(m.addr));
            end
        end
        if (mem_read_valid && p_mrv) chk("mra_stable", 32'(mem_read_address), 32'(p_mra));
        if (mem_write_valid && !p_mwv) begin
            chk("mreq_wr_expected", 32'(mq.size() > 0), 1);
            if (mq.size() > 0) begin
                m = mq.pop_front();
                chk("mreq_wr_kind", 32'(m.wr), 1);
                chk("mreq_wr_addr", 32'(mem_write_address), 32'(m.addr));
                chk("mreq_wr_data", 32'(mem_write_data), 32'(m.data));
            end
        end
        p_rr  = consumer_read_ready;
        p_wr  = consumer_write_ready;
        p_rv  = rv;
        p_wv  = wv;
        p_mrv = mem_read_valid;
        p_mwv = mem_write_valid;
        p_mra = mem_read_address;
        @(posedge clk);
        #1;
        rv = rv & ~p_rr;
        wv = wv & ~p_wr;
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
        if (mem_read_valid) begin
            if (rcnt >= lat) begin
                mem_read_ready = 1'b1;
                mem_read_data  = mem_arr[mem_read_address];
                rcnt = 0;
            end else rcnt++;
        end else rcnt = 0;
        if (inj_r) begin
            mem_read_ready = 1'b1;
            mem_read_data  = 8'hEE;
        end
        if (mem_write_valid) begin
            if (wcnt >= lat) begin
                mem_write_ready = 1'b1;
                mem_arr[mem_write_address] = mem_write_data;
                wcnt = 0;
            end else wcnt++;
        end else wcnt = 0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((rq.size() > 0 || mq.size() > 0 || rv != 0 || wv != 0 ||
                consumer_read_ready != 0 || consumer_write_ready != 0) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < budget), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 8'(i) ^ 8'h5A;
        mem_arr[8'h3C] = 8'hA5;

        // Reset held with every request asserted
        reset = 1'b0;
        rv = '1; wv = '1;
        rva = 32'h0403_0201; wva = 32'h1413_1211; wvd = 32'h2423_2221;
        tick(); tick();
        chk("rst_rd_ready", 32'(consumer_read_ready), 0);
        chk("rst_wr_ready", 32'(consumer_write_ready), 0);
        chk("rst_mrv", 32'(mem_read_valid), 0);
        chk("rst_mwv", 32'(mem_write_valid), 0);
        chk("rst_rd_data", consumer_read_data, 0);
        rv = '0; wv = '0; p_rv = '0; p_wv = '0;
        reset = 1'b1;
        tick();

        // Single read, three-cycle memory latency
        lat = 3;
        rva[2*AB +: AB] = 8'h3C;
        rv[2] = 1'b1;
        mq.push_back('{wr: 1'b0, addr: 8'h3C, data: 8'h00});
        rq.push_back('{wr: 1'b0, idx: 2, data: 8'hA5});
        drain("single_read_done", 60);
        chk("rd_data_hold", 32'(consumer_read_data[2*DB +: DB]), 32'h A5);

        // Single write
        wva[0 +: AB] = 8'h10;
        wvd[0 +: DB] = 8'h7E;
        wv[0] = 1'b1;
        mq.push_back('{wr: 1'b1, addr: 8'h10, data: 8'h7E});
        rq.push_back('{wr: 1'b1, idx: 0, data: 8'h00});
        drain("single_write_done", 60);
        chk("mem_written", 32'(mem_arr[8'h10]), 32'h7E);

        // Reset pulse so the round-robin pointer starts at 0
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // All four consumers read at once
        lat = 1;
        for (int i = 0; i < N; i++) begin
            rva[i*AB +: AB] = 8'(i);
            mq.push_back('{wr: 1'b0, addr: 8'(i), data: 8'h00});
            rq.push_back('{wr: 1'b0, idx: i, data: mem_arr[8'(i)]});
        end
        rv = '1;
        drain("rr_all_done", 200);

        // Consumers 3 and 0 again: pointer has wrapped to 0
        rva[0 +: AB] = 8'h08;
        rva[3*AB +: AB] = 8'h0B;
        mq.push_back('{wr: 1'b0, addr: 8'h08, data: 8'h00});
        mq.push_back('{wr: 1'b0, addr: 8'h0B, data: 8'h00});
        rq.push_back('{wr: 1'b0, idx: 0, data: mem_arr[8'h08]});
        rq.push_back('{wr: 1'b0, idx: 3, data: mem_arr[8'h0B]});
        rv = 4'b1001;
        drain("rr_wrap_done", 100);

        // Same consumer with read and write pending: read first
        lat = 0;
        rva[1*AB +: AB] = 8'h20;
        wva[1*AB +: AB] = 8'h21;
        wvd[1*DB +: DB] = 8'h55;
        mq.push_back('{wr: 1'b0, addr: 8'h20, data: 8'h00});
        mq.push_back('{wr: 1'b1, addr: 8'h21, data: 8'h55});
        rq.push_back('{wr: 1'b0, idx: 1, data: mem_arr[8'h20]});
        rq.push_back('{wr: 1'b1, idx: 1, data: 8'h00});
        rv[1] = 1'b1;
        wv[1] = 1'b1;
        drain("rw_same_done", 60);
        chk("mem_written_rw", 32'(mem_arr[8'h21]), 32'h55);

        // Reset while waiting on memory; the late completion must be ignored
        lat = 1000;
        rva[1*AB +: AB] = 8'h44;
        mq.push_back('{wr: 1'b0, addr: 8'h44, data: 8'h00});
        rv[1] = 1'b1;
        for (int n = 0; n < 20 && !mem_read_valid; n++) tick();
        chk("midrst_wait_reached", 32'(mem_read_valid), 1);
        reset = 1'b0;
        tick();
        chk("midrst_mrv_drop", 32'(mem_read_valid), 0);
        rv = '0; p_rv = '0;
        reset = 1'b1;
        inj_r = 1'b1;
        tick();
        inj_r = 1'b0;
        tick(); tick(); tick();
        chk("midrst_no_rd_ready", 32'(consumer_read_ready), 0);
        chk("midrst_no_wr_ready", 32'(consumer_write_ready), 0);
        chk("midrst_mrv_idle", 32'(mem_read_valid), 0);

        // Normal service resumes after the abandoned transaction
        lat = 0;
        rva[3*AB +: AB] = 8'h77;
        mq.push_back('{wr: 1'b0, addr: 8'h77, data: 8'h00});
        rq.push_back('{wr: 1'b0, idx: 3, data: mem_arr[8'h77]});
        rv[3] = 1'b1;
        drain("recover_done", 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
